// File: rtl/controller_modulo.sv
`default_nettype none
// ============================================================================
// Module      : controller_modulo
// Description : Sequencer for the modulo datapath. Computes Zahl1 mod Zahl2
//               by repeated subtraction: load, compare, terminate-check and
//               subtract phases, with a bounded iteration count.
//               Optional feature macro: ZERO_DIV_CHECK_EN (early error on a
//               zero divisor, no datapath activity for that request).
// Revision    : 1.0 - initial release
// ============================================================================
module controller_modulo #(
   parameter int          ALU_LAT  = 2,
   parameter logic [15:0] MAX_ITER = 16'hFFFF,
   parameter logic [2:0]  MODE_NOP = 3'd0,
   parameter logic [2:0]  MODE_SUB = 3'd1,
   parameter logic [2:0]  MODE_LT  = 3'd2
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [15:0] Zahl2_i,
   input  logic        valid_i,
   output logic [2:0]  alu_mode_o,
   output logic        wren_update_Zahlen_o,
   output logic        wren_Zahl1_to_erg_o,
   output logic        wren_term_erg_o,
   output logic        wren_res_to_erg_o,
   output logic        erg_to_alu_a_o,
   output logic        Zahl2_to_alu_b_o,
   output logic        check_for_termination_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   // Wait counter only needs to reach ALU_LAT-1
   localparam int                WAIT_W      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(ALU_LAT - 1);
   localparam logic [15:0]       c_iter_sat  = 16'hFFFF;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD_WAIT = 4'd1,
      S_UPDATE    = 4'd2,
      S_INIT      = 4'd3,
      S_CMP       = 4'd4,
      S_CMP_WB    = 4'd5,
      S_CHECK     = 4'd6,
      S_SUB       = 4'd7,
      S_SUB_WB    = 4'd8,
      S_DONE      = 4'd9,
      S_ERR       = 4'd10
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [15:0]       r_iter;

`ifdef ZERO_DIV_CHECK_EN
`else
   // Divisor is only consulted by the zero check
   logic w_unused_zahl2;
   assign w_unused_zahl2 = ^Zahl2_i;
`endif

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
`ifdef ZERO_DIV_CHECK_EN
               w_state_nxt = (Zahl2_i == 16'd0) ? S_ERR : S_LOAD_WAIT;
`else
               w_state_nxt = S_LOAD_WAIT;
`endif
            end
         end
         S_LOAD_WAIT: w_state_nxt = S_UPDATE;
         S_UPDATE:    w_state_nxt = S_INIT;
         S_INIT:      w_state_nxt = S_CMP;
         S_CMP:       if (r_wait == c_wait_last) w_state_nxt = S_CMP_WB;
         S_CMP_WB:    w_state_nxt = S_CHECK;
         S_CHECK: begin
            if (valid_i)                 w_state_nxt = S_DONE;
            else if (r_iter >= MAX_ITER) w_state_nxt = S_ERR;
            else                         w_state_nxt = S_SUB;
         end
         S_SUB:       if (r_wait == c_wait_last) w_state_nxt = S_SUB_WB;
         S_SUB_WB:    w_state_nxt = S_CMP;
         S_DONE:      w_state_nxt = S_IDLE;
         S_ERR:       w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // State, counters and registered output decode of the upcoming state
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state                 <= S_IDLE;
         r_wait                  <= '0;
         r_iter                  <= '0;
         alu_mode_o              <= MODE_NOP;
         wren_update_Zahlen_o    <= 1'b0;
         wren_Zahl1_to_erg_o     <= 1'b0;
         wren_term_erg_o         <= 1'b0;
         wren_res_to_erg_o       <= 1'b0;
         erg_to_alu_a_o          <= 1'b0;
         Zahl2_to_alu_b_o        <= 1'b0;
         check_for_termination_o <= 1'b0;
         busy_o                  <= 1'b0;
         done_o                  <= 1'b0;
         err_o                   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // Wait counter runs only while an ALU operation is in flight
         if ((r_state == S_CMP || r_state == S_SUB) && r_wait != c_wait_last)
            r_wait <= r_wait + 1'b1;
         else
            r_wait <= '0;

         // Iteration counter: cleared on accepted start, saturating count
         if (r_state == S_IDLE && start_i)
            r_iter <= '0;
         else if (r_state == S_SUB_WB && r_iter != c_iter_sat)
            r_iter <= r_iter + 16'd1;

         alu_mode_o              <= MODE_NOP;
         wren_update_Zahlen_o    <= 1'b0;
         wren_Zahl1_to_erg_o     <= 1'b0;
         wren_term_erg_o         <= 1'b0;
         wren_res_to_erg_o       <= 1'b0;
         erg_to_alu_a_o          <= 1'b0;
         Zahl2_to_alu_b_o        <= 1'b0;
         check_for_termination_o <= 1'b0;
         done_o                  <= 1'b0;
         err_o                   <= 1'b0;
         busy_o                  <= (w_state_nxt != S_IDLE);
         case (w_state_nxt)
            S_UPDATE: wren_update_Zahlen_o <= 1'b1;
            S_INIT:   wren_Zahl1_to_erg_o  <= 1'b1;
            S_CMP: begin
               alu_mode_o       <= MODE_LT;
               erg_to_alu_a_o   <= 1'b1;
               Zahl2_to_alu_b_o <= 1'b1;
            end
            S_CMP_WB: begin
               alu_mode_o       <= MODE_LT;
               erg_to_alu_a_o   <= 1'b1;
               Zahl2_to_alu_b_o <= 1'b1;
               wren_term_erg_o  <= 1'b1;
            end
            S_CHECK:  check_for_termination_o <= 1'b1;
            S_SUB: begin
               alu_mode_o       <= MODE_SUB;
               erg_to_alu_a_o   <= 1'b1;
               Zahl2_to_alu_b_o <= 1'b1;
            end
            S_SUB_WB: begin
               alu_mode_o        <= MODE_SUB;
               erg_to_alu_a_o    <= 1'b1;
               Zahl2_to_alu_b_o  <= 1'b1;
               wren_res_to_erg_o <= 1'b1;
            end
            S_DONE:   done_o <= 1'b1;
            S_ERR: begin
               done_o <= 1'b1;
               err_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controller_modulo.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_modulo
// Description : Self-checking bench for controller_modulo. A small behavioural
//               datapath answers the termination check; expected timing and
//               results come from closed-form arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controller_modulo;

   localparam int L    = 2;
   localparam int MAXI = 4;

   logic        clk     = 1'b0;
   logic        rst_ni  = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] Zahl2_i = 16'd0;
   logic        valid_i = 1'b0;
   logic [2:0]  alu_mode_o;
   logic        wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o, wren_res_to_erg_o;
   logic        erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o;
   logic        busy_o, done_o, err_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   controller_modulo #(.ALU_LAT(L), .MAX_ITER(16'(MAXI))) dut (
      .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .Zahl2_i(Zahl2_i), .valid_i(valid_i),
      .alu_mode_o(alu_mode_o),
      .wren_update_Zahlen_o(wren_update_Zahlen_o), .wren_Zahl1_to_erg_o(wren_Zahl1_to_erg_o),
      .wren_term_erg_o(wren_term_erg_o), .wren_res_to_erg_o(wren_res_to_erg_o),
      .erg_to_alu_a_o(erg_to_alu_a_o), .Zahl2_to_alu_b_o(Zahl2_to_alu_b_o),
      .check_for_termination_o(check_for_termination_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

   function automatic logic [13:0] all_outs();
      return {alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o, wren_term_erg_o,
              wren_res_to_erg_o, erg_to_alu_a_o, Zahl2_to_alu_b_o, check_for_termination_o,
              busy_o, done_o, err_o};
   endfunction

   // Reference: quotient-based iteration count and closed-form completion cycle
   function automatic void model(input int z1, input int z2, output int done_cyc,
                                 output bit err, output int k, output int chk, output int erg);
      int q;
`ifdef ZERO_DIV_CHECK_EN
      if (z2 == 0) begin
         done_cyc = 1; err = 1'b1; k = 0; chk = 0; erg = 0;
         return;
      end
`endif
      q        = (z2 == 0) ? MAXI + 1 : z1 / z2;
      err      = (q > MAXI);
      k        = err ? MAXI : q;
      chk      = k + 1;
      erg      = (z2 == 0) ? z1 : z1 % z2;
      done_cyc = 6 + L + k * (3 + 2 * L);
   endfunction

   // Runs one operation with a behavioural datapath; observes the controller
   task automatic do_op(input int z1, input int z2, input bit noisy,
                        output int done_cyc, output bit err, output int n_sub, output int n_chk,
                        output int first_chk, output int erg, output int n_wren, output int viol);
      done_cyc = -1; err = 1'b0; n_sub = 0; n_chk = 0; first_chk = -1; erg = 0; n_wren = 0; viol = 0;
      @(negedge clk);
      start_i = 1'b1;
      Zahl2_i = 16'(z2);
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start_i = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         if (int'(wren_update_Zahlen_o) + int'(wren_Zahl1_to_erg_o) +
             int'(wren_term_erg_o) + int'(wren_res_to_erg_o) > 1) viol++;
         if (wren_update_Zahlen_o || wren_Zahl1_to_erg_o || wren_term_erg_o || wren_res_to_erg_o)
            n_wren++;
         if (!busy_o) viol++;
         if (err_o && !done_o) viol++;
         if (wren_term_erg_o && (alu_mode_o != 3'd2 || !erg_to_alu_a_o || !Zahl2_to_alu_b_o)) viol++;
         if (wren_res_to_erg_o && (alu_mode_o != 3'd1 || !erg_to_alu_a_o || !Zahl2_to_alu_b_o)) viol++;
         if (wren_Zahl1_to_erg_o) erg = z1;
         if (wren_res_to_erg_o) begin
            erg = erg - z2;
            n_sub++;
         end
         if (check_for_termination_o) begin
            n_chk++;
            if (first_chk < 0) first_chk = c;
            valid_i = (erg < z2);
         end else begin
            valid_i = 1'($urandom_range(0, 1));
         end
         if (done_o) begin
            done_cyc = c;
            err      = err_o;
            start_i  = 1'b0;
            break;
         end
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (all_outs() !== 14'd0) begin
         n_bad++;
         $display("FAIL reset_outs got=%h exp=%h", all_outs(), 14'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (all_outs() !== 14'd0) begin
         n_bad++;
         $display("FAIL idle_outs got=%h exp=%h", all_outs(), 14'd0);
      end
   endtask

   task automatic test_normal();
      int d, ns, nc, fc, e, nw, v; bit er;
      do_op(10, 3, 1'b0, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (d !== 29) begin n_bad++; $display("FAIL normal_done got=%0d exp=29", d); end
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL normal_err got=%0d exp=0", er); end
      n_cmp++; if (fc !== 7) begin n_bad++; $display("FAIL normal_first_check got=%0d exp=7", fc); end
      n_cmp++; if (nc !== 4) begin n_bad++; $display("FAIL normal_checks got=%0d exp=4", nc); end
      n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL normal_erg got=%0d exp=1", e); end
      n_cmp++; if (v !== 0) begin n_bad++; $display("FAIL normal_flags got=%0d exp=0", v); end
   endtask

   task automatic test_immediate();
      int d, ns, nc, fc, e, nw, v; bit er;
      do_op(2, 5, 1'b0, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (d !== 8) begin n_bad++; $display("FAIL imm_done got=%0d exp=8", d); end
      n_cmp++; if (ns !== 0) begin n_bad++; $display("FAIL imm_subs got=%0d exp=0", ns); end
      n_cmp++; if (e !== 2) begin n_bad++; $display("FAIL imm_erg got=%0d exp=2", e); end
   endtask

   task automatic test_timeout();
      int d, ns, nc, fc, e, nw, v; bit er;
      do_op(100, 1, 1'b0, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (ns !== MAXI) begin n_bad++; $display("FAIL tmo_subs got=%0d exp=%0d", ns, MAXI); end
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL tmo_err got=%0d exp=1", er); end
      n_cmp++; if (d !== 6 + L + MAXI * (3 + 2 * L)) begin
         n_bad++; $display("FAIL tmo_done got=%0d exp=%0d", d, 6 + L + MAXI * (3 + 2 * L)); end
      @(negedge clk);
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_after got=%0d exp=0", busy_o); end
   endtask

   task automatic test_zero_div();
      int d, ns, nc, fc, e, nw, v, xd, xk, xc, xe; bit er, xer;
      model(7, 0, xd, xer, xk, xc, xe);
      do_op(7, 0, 1'b0, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (d !== xd) begin n_bad++; $display("FAIL zdiv_done got=%0d exp=%0d", d, xd); end
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL zdiv_err got=%0d exp=1", er); end
      n_cmp++; if (ns !== xk) begin n_bad++; $display("FAIL zdiv_subs got=%0d exp=%0d", ns, xk); end
`ifdef ZERO_DIV_CHECK_EN
      n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL zdiv_wren got=%0d exp=0", nw); end
`endif
   endtask

   task automatic test_back_to_back();
      int d, ns, nc, fc, e, nw, v, extra; bit er;
      do_op(17, 4, 1'b1, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (d !== 6 + L + 4 * (3 + 2 * L)) begin
         n_bad++; $display("FAIL b2b_done got=%0d exp=%0d", d, 6 + L + 4 * (3 + 2 * L)); end
      n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL b2b_erg got=%0d exp=1", e); end
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done_o || busy_o) extra++;
      end
      n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL b2b_single_done got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid_sub();
      int seen, dones, d, ns, nc, fc, e, nw, v; bit er;
      seen = 0; dones = 0;
      @(negedge clk);
      start_i = 1'b1;
      Zahl2_i = 16'd3;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         valid_i = 1'b0;
         if (alu_mode_o == 3'd1 && !wren_res_to_erg_o) begin
            seen = 1;
            break;
         end
      end
      n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL rst_reach_sub got=%0d exp=1", seen); end
      #1 rst_ni = 1'b0;
      #1;
      n_cmp++; if (all_outs() !== 14'd0) begin
         n_bad++; $display("FAIL rst_mid_outs got=%h exp=%h", all_outs(), 14'd0); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done_o || busy_o) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
      do_op(10, 3, 1'b0, d, er, ns, nc, fc, e, nw, v);
      n_cmp++; if (d !== 29 || er !== 1'b0 || e !== 1) begin
         n_bad++; $display("FAIL rst_fresh_op got=%0d/%0d/%0d exp=29/0/1", d, er, e); end
   endtask

   task automatic test_random();
      int z1, z2, d, ns, nc, fc, e, nw, v, xd, xk, xc, xe; bit er, xer;
      for (int i = 0; i < 25; i++) begin
         z1 = $urandom_range(0, 60);
         z2 = $urandom_range(0, 12);
         model(z1, z2, xd, xer, xk, xc, xe);
         do_op(z1, z2, 1'($urandom_range(0, 1)), d, er, ns, nc, fc, e, nw, v);
         n_cmp++; if (d !== xd) begin n_bad++; $display("FAIL rnd_done %0d/%0d got=%0d exp=%0d", z1, z2, d, xd); end
         n_cmp++; if (er !== xer) begin n_bad++; $display("FAIL rnd_err %0d/%0d got=%0d exp=%0d", z1, z2, er, xer); end
         n_cmp++; if (ns !== xk) begin n_bad++; $display("FAIL rnd_subs %0d/%0d got=%0d exp=%0d", z1, z2, ns, xk); end
         n_cmp++; if (nc !== xc) begin n_bad++; $display("FAIL rnd_checks %0d/%0d got=%0d exp=%0d", z1, z2, nc, xc); end
         n_cmp++; if (v !== 0) begin n_bad++; $display("FAIL rnd_flags %0d/%0d got=%0d exp=0", z1, z2, v); end
         if (!xer) begin
            n_cmp++; if (e !== xe) begin n_bad++; $display("FAIL rnd_erg %0d/%0d got=%0d exp=%0d", z1, z2, e, xe); end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_immediate();
      test_timeout();
      test_zero_div();
      test_back_to_back();
      test_reset_mid_sub();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
